exe_muldiv: RTL

Iterative multiply/divide unit in the EXE stage, directly downstream of the ID/EXE pipeline register. It consumes the registered rs/rt operands and the mul/div control decoded in ID, and computes MULT/MULTU/DIV/DIVU over 33 cycles. Results go into internal HI/LO registers. While an operation is in flight, `busy` is held high so the hazard logic stalls IF/ID and ID/EXE.

---
 rtl/exe_muldiv_if.sv | 44 ++++
 rtl/exe_muldiv.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_if.sv
// ---------------------------------------------------------------------------
// exe_muldiv_if
//   Bundles the control, operand and result signals of the EXE-stage
//   multiply/divide unit so the unit and whoever drives it share one port.
//
//   slave  (the unit itself):
//     in  start      request an operation this cycle
//     in  op[1:0]    00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//     in  readData1  rs operand (multiplicand / dividend), also MTHI/MTLO data
//     in  readData2  rt operand (multiplier / divisor)
//     in  mthi       write readData1 into HI
//     in  mtlo       write readData1 into LO
//     out hiOut      HI register
//     out loOut      LO register
//     out busy       operation in flight, stalls IF/ID and ID/EXE
//     out done       one-cycle pulse after HI/LO were written
//     out divByZero  pulses with done when a divide had divisor 0
//   master (ID/EXE side / testbench): the mirror image.
// ---------------------------------------------------------------------------
interface exe_muldiv_if;

  logic        start;
  logic [1:0]  op;
  logic [31:0] readData1;
  logic [31:0] readData2;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hiOut;
  logic [31:0] loOut;
  logic        busy;
  logic        done;
  logic        divByZero;

  modport slave (
    input  start, op, readData1, readData2, mthi, mtlo,
    output hiOut, loOut, busy, done, divByZero
  );

  modport master (
    output start, op, readData1, readData2, mthi, mtlo,
    input  hiOut, loOut, busy, done, divByZero
  );

endinterface

// File: rtl/exe_muldiv.sv
// ---------------------------------------------------------------------------
// exe_muldiv
//   Iterative 32-bit multiply/divide unit for the EXE stage. MULT/MULTU use
//   a shift-add multiplier, DIV/DIVU a restoring divider, both working on
//   unsigned magnitudes with a sign fix-up at the end. One operation takes
//   33 cycles of busy (1 RUN entry, 32 iterations ending in FIX, 1 FIX).
//
//   Ports:
//     clock  in   single clock, all state changes on posedge
//     reset  in   synchronous active-high, clears all state
//     bus    slave modport of exe_muldiv_if (start/op/operands/mthi/mtlo in,
//                 hiOut/loOut/busy/done/divByZero out)
// ---------------------------------------------------------------------------
module exe_muldiv (
  input  logic          clock,
  input  logic          reset,
  exe_muldiv_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [1:0]  op_q;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] orig_rs;
  logic [63:0] acc;
  logic [4:0]  cnt;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        busy_q;
  logic        done_q;
  logic        dbz_q;

  // Operand preparation for a new request: signed ops (op[0]==0) take
  // magnitudes and remember the signs; unsigned ops keep the raw values
  // and never see a sign flag, so the fix-up needs no op check.
  logic        in_signed;
  logic        in_sign_a;
  logic        in_sign_b;
  logic [31:0] in_mag_a;
  logic [31:0] in_mag_b;

  always_comb begin
    in_signed = ~bus.op[0];
    in_sign_a = in_signed & bus.readData1[31];
    in_sign_b = in_signed & bus.readData2[31];
    in_mag_a  = in_sign_a ? (~bus.readData1 + 32'd1) : bus.readData1;
    in_mag_b  = in_sign_b ? (~bus.readData2 + 32'd1) : bus.readData2;
  end

  // One iteration of each algorithm. The accumulator is shared:
  //  multiply: acc[63:32] is the running partial product, acc[31:0] holds
  //            the multiplier and is shifted out LSB first while product
  //            bits shift in from the top.
  //  divide:   acc[63:32] is the partial remainder, acc[31:0] holds the
  //            dividend shifted out MSB first while quotient bits enter
  //            at the bottom.
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [32:0] div_shift;
  logic [33:0] div_diff;
  logic [63:0] div_next;

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, mag_a} : 33'd0);
    mul_next  = {mul_sum, acc[31:1]};
    div_shift = {acc[63:32], acc[31]};
    div_diff  = {1'b0, div_shift} - {2'b00, mag_b};
    // A negative trial difference restores the shifted remainder. That
    // remainder is below the divisor, so its top bit is always zero.
    if (div_diff[33]) begin
      div_next = {div_shift[31:0], acc[30:0], 1'b0};
    end else begin
      div_next = {div_diff[31:0], acc[30:0], 1'b1};
    end
  end

  // Sign fix-up and final HI/LO selection computed during FIX.
  logic        is_div;
  logic        div_zero;
  logic [63:0] product;
  logic [31:0] quo;
  logic [31:0] rem;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  always_comb begin
    is_div   = op_q[1];
    div_zero = (mag_b == 32'd0);
    product  = (sign_a ^ sign_b) ? (~acc + 64'd1) : acc;
    quo      = (sign_a ^ sign_b) ? (~acc[31:0] + 32'd1) : acc[31:0];
    rem      = sign_a ? (~acc[63:32] + 32'd1) : acc[63:32];
    fix_hi   = product[63:32];
    fix_lo   = product[31:0];
    if (is_div) begin
      if (div_zero) begin
        fix_hi = orig_rs;
        fix_lo = 32'hFFFF_FFFF;
      end else begin
        fix_hi = rem;
        fix_lo = quo;
      end
    end
  end

  // Next-state logic: IDLE waits for start, RUN counts 32 iterations,
  // FIX always returns to IDLE after one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == 5'd31) state_next = FIX;
      FIX:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath. busy is derived from the next state so it
  // is a plain flop output that rises on the edge that accepts start.
  // mthi/mtlo only act in IDLE; if they coincide with start the FIX write
  // later overwrites them.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      op_q    <= 2'b00;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      mag_a   <= 32'd0;
      mag_b   <= 32'd0;
      orig_rs <= 32'd0;
      acc     <= 64'd0;
      cnt     <= 5'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state  <= state_next;
      busy_q <= (state_next != IDLE);
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mthi) hi_q <= bus.readData1;
          if (bus.mtlo) lo_q <= bus.readData1;
          if (bus.start) begin
            op_q    <= bus.op;
            sign_a  <= in_sign_a;
            sign_b  <= in_sign_b;
            mag_a   <= in_mag_a;
            mag_b   <= in_mag_b;
            orig_rs <= bus.readData1;
            cnt     <= 5'd0;
            // Upper half cleared; lower half seeded with the operand that
            // gets shifted out (multiplier or dividend).
            acc     <= bus.op[1] ? {32'd0, in_mag_a} : {32'd0, in_mag_b};
          end
        end
        RUN: begin
          acc <= is_div ? div_next : mul_next;
          cnt <= cnt + 5'd1;
        end
        FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          dbz_q  <= is_div & div_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.hiOut     = hi_q;
  assign bus.loOut     = lo_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.divByZero = dbz_q;

endmodule
